// File: rtl/spdif_frame_tx_if.sv
// Sample-pair handshake bundle for the S/PDIF frame transmitter.
// master = sample source, slave = transmitter.
interface spdif_frame_tx_if #(
    parameter int SAMPLE_W = 24
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, s_left, s_right, input s_ready);
    modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/spdif_frame_tx.sv
// IEC 60958 consumer transmitter: builds 192-frame blocks from PCM pairs
// and biphase-mark encodes them onto spdif_o, one UI per CLK_DIV clocks.
module spdif_frame_tx #(
    parameter int SAMPLE_W = 24,
    parameter int CLK_DIV  = 2
) (
    input  logic               iClk,
    input  logic               rst_n,
    input  logic               en,
    spdif_frame_tx_if.slave    s,
    input  logic [39:0]        cs_bits,
    output logic               spdif_o,
    output logic               frame_start,
    output logic               block_start,
    output logic               underrun
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {IDLE, TX} state_t;

    state_t              state;
    logic [DW-1:0]       div;
    logic [6:0]          ui;      // bit 6 selects subframe B
    logic [7:0]          frame;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [23:0]         aud_a, aud_b;
    logic                v_bit;
    logic                pre_lvl;

    logic        load, xfer, c_bit, data_bit, pre_ref, nxt;
    logic [4:0]  slot;
    logic [7:0]  pre_pat;
    logic [23:0] aud;
    logic [31:0] word;

    assign s.s_ready = !hold_full;
    assign xfer      = s.s_valid && !hold_full;
    assign load      = (state == TX) && en && (div == '0) && (ui == '0);

    assign slot    = ui[5:1];
    assign pre_pat = ui[6] ? 8'b11100100 : ((frame == 8'd0) ? 8'b11101000 : 8'b11100010);
    assign c_bit   = (frame < 8'd40) ? cs_bits[frame[5:0]] : 1'b0;
    assign aud     = ui[6] ? aud_b : aud_a;
    // Slots 4..31 as bits 0..27; top nibble pads the index range of slots 0..3.
    assign word     = {4'b0, ^{c_bit, v_bit, aud}, c_bit, 1'b0, v_bit, aud};
    assign data_bit = word[slot - 5'd4];
    assign pre_ref  = (ui[5:0] == 6'd0) ? spdif_o : pre_lvl;

    always_comb begin
        nxt = spdif_o;
        if (ui[5:0] < 6'd8)
            nxt = pre_pat[~ui[2:0]] ^ pre_ref;
        else if (!ui[0])
            nxt = ~spdif_o;
        else
            nxt = spdif_o ^ data_bit;
    end

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= '0;
            ui          <= '0;
            frame       <= '0;
            spdif_o     <= 1'b0;
            frame_start <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            aud_a       <= '0;
            aud_b       <= '0;
            v_bit       <= 1'b0;
            pre_lvl     <= 1'b0;
        end else begin
            frame_start <= load;
            block_start <= load && (frame == 8'd0);
            underrun    <= load && !hold_full;
            if (load) begin
                if (hold_full) begin
                    aud_a <= 24'(hold_l) << (24 - SAMPLE_W);
                    aud_b <= 24'(hold_r) << (24 - SAMPLE_W);
                    v_bit <= 1'b0;
                end else begin
                    aud_a <= '0;
                    aud_b <= '0;
                    v_bit <= 1'b1;
                end
            end
            // No bypass: a pair taken on the load edge waits for the next frame.
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (xfer) begin
                hold_full <= 1'b1;
                hold_l    <= s.s_left;
                hold_r    <= s.s_right;
            end
            case (state)
                IDLE: begin
                    spdif_o <= 1'b0;
                    if (en) begin
                        state <= TX;
                        div   <= '0;
                        ui    <= '0;
                        frame <= '0;
                    end
                end
                TX: begin
                    if (!en) begin
                        state   <= IDLE;
                        spdif_o <= 1'b0;
                        div     <= '0;
                        ui      <= '0;
                        frame   <= '0;
                    end else begin
                        if (div == '0) begin
                            spdif_o <= nxt;
                            if (ui[5:0] == 6'd0) pre_lvl <= spdif_o;
                        end
                        if (div == DIV_LAST) begin
                            div <= '0;
                            ui  <= ui + 7'd1;
                            if (ui == 7'd127)
                                frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
                        end else begin
                            div <= div + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spdif_frame_tx.sv
// Directed bench for spdif_frame_tx: captures whole frames UI by UI, decodes
// the biphase slots and compares against hand-derived slot words.
module tb_spdif_frame_tx;
    localparam int CD = 2;

    logic iClk = 0;
    logic rst_n, en1, en2;
    logic [39:0] cs1, cs2;
    logic o1, fs1, bs1, ur1, o2, fs2, bs2, ur2;
    int tests = 0, fails = 0, cyc = 0;

    spdif_frame_tx_if #(.SAMPLE_W(24)) bus1();
    spdif_frame_tx_if #(.SAMPLE_W(16)) bus2();

    spdif_frame_tx #(.SAMPLE_W(24), .CLK_DIV(CD)) dut1 (
        .iClk(iClk), .rst_n(rst_n), .en(en1), .s(bus1), .cs_bits(cs1),
        .spdif_o(o1), .frame_start(fs1), .block_start(bs1), .underrun(ur1));
    spdif_frame_tx #(.SAMPLE_W(16), .CLK_DIV(CD)) dut2 (
        .iClk(iClk), .rst_n(rst_n), .en(en2), .s(bus2), .cs_bits(cs2),
        .spdif_o(o2), .frame_start(fs2), .block_start(bs2), .underrun(ur2));

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc++;

    logic        ui_cap [128];
    logic [27:0] word_a, word_b;
    logic [7:0]  pre_a, pre_b;
    logic        bs_c, ur_c, rdy_c;
    int          terr, cyc_c;

    // Waits (bounded) for frame_start, then records 128 UIs and decodes them.
    task automatic capture(input bit d);
        int n;
        logic a, b;
        n = 0;
        while (!(d ? fs2 : fs1) && n < 2000) begin @(negedge iClk); n++; end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL capture_timeout: no frame_start within %0d cycles", n);
        end
        bs_c = d ? bs2 : bs1; ur_c = d ? ur2 : ur1;
        rdy_c = d ? bus2.s_ready : bus1.s_ready; cyc_c = cyc; terr = 0;
        for (int i = 0; i < 128; i++) begin
            a = d ? o2 : o1; @(negedge iClk);
            b = d ? o2 : o1; @(negedge iClk);
            if (a !== b) terr++;
            ui_cap[i] = a;
        end
        for (int i = 0; i < 8; i++) begin
            pre_a[7-i] = ui_cap[i];
            pre_b[7-i] = ui_cap[64+i];
        end
        for (int sl = 4; sl < 32; sl++) begin
            word_a[sl-4] = ui_cap[2*sl] ^ ui_cap[2*sl+1];
            word_b[sl-4] = ui_cap[64+2*sl] ^ ui_cap[64+2*sl+1];
            if (ui_cap[2*sl] === ui_cap[2*sl-1]) terr++;
            if (ui_cap[64+2*sl] === ui_cap[64+2*sl-1]) terr++;
        end
        if (ui_cap[63] !== 1'b0 || ui_cap[127] !== 1'b0) terr++;
    endtask

    task automatic test_reset;
        rst_n = 0; en1 = 0; en2 = 0; cs1 = '0; cs2 = '0;
        bus1.s_valid = 0; bus1.s_left = '0; bus1.s_right = '0;
        bus2.s_valid = 0; bus2.s_left = '0; bus2.s_right = '0;
        repeat (3) @(negedge iClk);
        tests++; if ({o1, fs1, bs1, ur1} !== 4'b0) begin fails++;
            $display("FAIL reset_outs: got %b want 0000", {o1, fs1, bs1, ur1}); end
        tests++; if ({bus1.s_ready, bus2.s_ready} !== 2'b11) begin fails++;
            $display("FAIL reset_ready: got %b want 11", {bus1.s_ready, bus2.s_ready}); end
        rst_n = 1;
        repeat (4) @(negedge iClk);
        tests++; if ({o1, fs1, o2, fs2} !== 4'b0) begin fails++;
            $display("FAIL idle_quiet: got %b want 0000", {o1, fs1, o2, fs2}); end
    endtask

    task automatic test_underrun;
        en1 = 1;
        @(negedge iClk);
        tests++; if ({fs1, o1} !== 2'b00) begin fails++;
            $display("FAIL start_early: fs/o got %b want 00", {fs1, o1}); end
        @(negedge iClk);
        tests++; if ({fs1, bs1, ur1, o1} !== 4'b1111) begin fails++;
            $display("FAIL start_edge: fs/bs/ur/o got %b want 1111", {fs1, bs1, ur1, o1}); end
        capture(0);
        tests++; if (pre_a !== 8'b11101000 || pre_b !== 8'b11100100) begin fails++;
            $display("FAIL pre_b_w: got %b/%b want 11101000/11100100", pre_a, pre_b); end
        tests++; if (word_a !== 28'h9000000 || word_b !== 28'h9000000) begin fails++;
            $display("FAIL underrun_words: got %h/%h want 9000000", word_a, word_b); end
        tests++; if (terr !== 0) begin fails++;
            $display("FAIL coding_f0: %0d biphase errors want 0", terr); end
        capture(0);
        tests++; if ({bs_c, ur_c} !== 2'b01 || pre_a !== 8'b11100010) begin fails++;
            $display("FAIL frame1: bs/ur %b pre %b want 01/11100010", {bs_c, ur_c}, pre_a); end
    endtask

    task automatic test_en_drop;
        int n;
        n = 0;
        repeat (11) @(negedge iClk);
        while (o1 !== 1'b1 && n < 100) begin @(negedge iClk); n++; end
        en1 = 0;
        @(negedge iClk);
        tests++; if (o1 !== 1'b0) begin fails++;
            $display("FAIL en_drop: spdif_o got %b want 0", o1); end
        n = 0;
        repeat (6) begin @(negedge iClk); if (o1 !== 1'b0 || fs1 !== 1'b0) n++; end
        tests++; if (n !== 0) begin fails++;
            $display("FAIL idle_hold: %0d active cycles want 0", n); end
    endtask

    task automatic test_single_pair;
        bus1.s_valid = 1; bus1.s_left = 24'h000001; bus1.s_right = 24'h0;
        @(negedge iClk);
        tests++; if (bus1.s_ready !== 1'b0) begin fails++;
            $display("FAIL ready_drop: got %b want 0", bus1.s_ready); end
        bus1.s_left = 24'hABCDEF; bus1.s_right = 24'h111111;
        repeat (4) @(negedge iClk);
        bus1.s_valid = 0;
        en1 = 1;
        capture(0);
        tests++; if ({bs_c, ur_c, rdy_c} !== 3'b101) begin fails++;
            $display("FAIL pair_start: bs/ur/ready got %b want 101", {bs_c, ur_c, rdy_c}); end
        tests++; if (word_a !== 28'h8000001 || {ui_cap[8], ui_cap[9]} !== 2'b10) begin fails++;
            $display("FAIL pair_left: word %h slot4 %b want 8000001/10", word_a, {ui_cap[8], ui_cap[9]}); end
        tests++; if (word_b !== 28'h0 || pre_b !== 8'b11100100 || terr !== 0) begin fails++;
            $display("FAIL pair_right: word %h pre %b err %0d want 0/11100100/0", word_b, pre_b, terr); end
        capture(0);
        tests++; if (ur_c !== 1'b1 || word_a !== 28'h9000000) begin fails++;
            $display("FAIL no_second_xfer: ur %b word %h want 1/9000000", ur_c, word_a); end
        en1 = 0;
        @(negedge iClk);
    endtask

    task automatic test_load_edge;
        en1 = 1;
        @(negedge iClk);
        bus1.s_valid = 1; bus1.s_left = 24'h800000; bus1.s_right = 24'h000003;
        @(negedge iClk);
        bus1.s_valid = 0;
        tests++; if ({fs1, ur1, bus1.s_ready} !== 3'b110) begin fails++;
            $display("FAIL load_edge: fs/ur/ready got %b want 110", {fs1, ur1, bus1.s_ready}); end
        capture(0);
        tests++; if (word_a !== 28'h9000000) begin fails++;
            $display("FAIL load_edge_f0: word %h want 9000000", word_a); end
        capture(0);
        tests++; if (ur_c !== 1'b0 || word_a !== 28'h8800000 || word_b !== 28'h0000003) begin fails++;
            $display("FAIL load_edge_f1: ur %b words %h/%h want 0/8800000/0000003", ur_c, word_a, word_b); end
    endtask

    task automatic test_restart;
        bus1.s_valid = 1; bus1.s_left = 24'h0000F0; bus1.s_right = 24'h123456;
        @(negedge iClk);
        bus1.s_valid = 0;
        repeat (30) @(negedge iClk);
        en1 = 0;
        @(negedge iClk);
        tests++; if ({o1, bus1.s_ready} !== 2'b00) begin fails++;
            $display("FAIL restart_stop: o/ready got %b want 00", {o1, bus1.s_ready}); end
        repeat (3) @(negedge iClk);
        en1 = 1;
        capture(0);
        tests++; if ({bs_c, ur_c} !== 2'b10 || pre_a !== 8'b11101000) begin fails++;
            $display("FAIL restart_hdr: bs/ur %b pre %b want 10/11101000", {bs_c, ur_c}, pre_a); end
        tests++; if (word_a !== 28'h00000F0 || word_b !== 28'h8123456) begin fails++;
            $display("FAIL restart_data: words %h/%h want 00000F0/8123456", word_a, word_b); end
        en1 = 0;
        @(negedge iClk);
    endtask

    task automatic test_block;
        int bad, c0;
        cs1 = 40'h1;
        bus1.s_valid = 1; bus1.s_left = '0; bus1.s_right = '0;
        repeat (3) @(negedge iClk);
        en1 = 1;
        capture(0);
        c0 = cyc_c;
        tests++; if ({bs_c, ur_c} !== 2'b10 || word_a !== 28'hC000000 || word_b !== 28'hC000000) begin fails++;
            $display("FAIL cs_f0: bs/ur %b words %h/%h want 10/C000000", {bs_c, ur_c}, word_a, word_b); end
        capture(0);
        tests++; if (pre_a !== 8'b11100010 || word_a !== 28'h0 || word_b !== 28'h0) begin fails++;
            $display("FAIL cs_f1: pre %b words %h/%h want 11100010/0/0", pre_a, word_a, word_b); end
        bad = 0;
        for (int f = 2; f < 192; f++) begin
            capture(0);
            if (word_a !== 28'h0 || word_b !== 28'h0 || ur_c !== 1'b0 || bs_c !== 1'b0) bad++;
            bad += terr;
        end
        tests++; if (bad !== 0) begin fails++;
            $display("FAIL block_body: %0d bad frames want 0", bad); end
        capture(0);
        tests++; if (bs_c !== 1'b1 || (cyc_c - c0) !== 192 * 128 * CD || word_a !== 28'hC000000) begin fails++;
            $display("FAIL block_wrap: bs %b period %0d word %h want 1/%0d/C000000", bs_c, cyc_c - c0, word_a, 192 * 128 * CD); end
        en1 = 0; bus1.s_valid = 0; cs1 = '0;
        @(negedge iClk);
    endtask

    task automatic test_sw16;
        bus2.s_valid = 1; bus2.s_left = 16'h8001; bus2.s_right = 16'h0;
        @(negedge iClk);
        bus2.s_valid = 0;
        en2 = 1;
        capture(1);
        tests++; if ({bs_c, ur_c} !== 2'b10 || pre_a !== 8'b11101000) begin fails++;
            $display("FAIL sw16_hdr: bs/ur %b pre %b want 10/11101000", {bs_c, ur_c}, pre_a); end
        tests++; if (word_a !== 28'h0800100 || word_b !== 28'h0 || terr !== 0) begin fails++;
            $display("FAIL sw16_data: words %h/%h err %0d want 0800100/0/0", word_a, word_b, terr); end
        en2 = 0;
    endtask

    task automatic test_reset_mid;
        bus1.s_valid = 1; bus1.s_left = 24'h5; bus1.s_right = 24'h6;
        @(negedge iClk);
        bus1.s_valid = 0;
        en1 = 1;
        repeat (41) @(negedge iClk);
        rst_n = 0;
        #1;
        tests++; if ({o1, fs1, bus1.s_ready} !== 3'b001) begin fails++;
            $display("FAIL reset_mid: o/fs/ready got %b want 001", {o1, fs1, bus1.s_ready}); end
        en1 = 0;
        @(negedge iClk);
        rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_underrun;
        test_en_drop;
        test_single_pair;
        test_load_edge;
        test_restart;
        test_block;
        test_sw16;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spdif_frame_tx.md
Name: spdif_frame_tx

Overview:
Synthesisable S/PDIF (IEC 60958 consumer) transmitter. Accepts stereo PCM sample pairs over a valid/ready handshake and builds 192-frame blocks. Each block carries B/M/W preambles, audio, V/U/C/P bits and a 40-bit programmable channel-status word. The block biphase-mark encodes this onto one serial line that drives iSPDIFin of spdif_if, replacing the behavioural traffic source with a parametrised RTL generator.

Parameters:
SAMPLE_W, 24, audio sample width, legal 16..24, left-aligned into the 24-bit field.
CLK_DIV, 2, iClk cycles per unit interval (UI = half bit cell), legal >= 1.

Ports:
iClk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  transmit enable.
s_valid  input  1  sample pair valid.
s_ready  output  1  holding register empty (= !hold_full, combinational).
s_left  input  SAMPLE_W  channel A sample.
s_right  input  SAMPLE_W  channel B sample.
cs_bits  input  40  channel-status bits 0..39 (bit i sent in frame i); frames 40..191 send C=0.
spdif_o  output  1  biphase-mark serial output.
frame_start  output  1  one-cycle pulse at the first UI of every frame.
block_start  output  1  one-cycle pulse at the first UI of frame 0.
underrun  output  1  one-cycle pulse when a frame starts with the holding register empty.

Behaviour:
- Reset (async): spdif_o=0, frame_start=block_start=underrun=0, all counters 0, holding register empty (s_ready=1), state IDLE.
- Handshake: transfer when s_valid&&s_ready. The pair goes into a one-entry holding register. s_ready drops the cycle after the transfer and stays low until the frame load empties the register. Accepting is independent of en.
- States: IDLE and TX.
  - IDLE: spdif_o=0.
  - en sampled 1 at edge k while in IDLE moves to TX. At edge k+1 spdif_o takes UI0 of frame 0 subframe A, block_start=frame_start=1 for that cycle, and the frame load occurs.
- Timing:
  - Divider 0..CLK_DIV-1; each UI level holds exactly CLK_DIV cycles.
  - A subframe is 64 UIs (32 slots x 2); a frame is 2 subframes; a block is 192 frames.
  - The frame counter wraps 191->0. block_start coincides with the frame 0 frame_start.
- Frame load at the first UI of each frame:
  - Holding register full: its contents move to the shift registers, V=0, holding register empties.
  - Holding register empty: both samples are 0, V=1 for both subframes, underrun pulses.
  - A pair accepted at the load edge itself goes to the holding register for the next frame. There is no bypass.
- Subframe slot map:
  - Slots 0-3: preamble.
  - Slots 4-27: 24-bit audio field, LSB first. SAMPLE_W bits occupy slots 28-SAMPLE_W..27 (MSB at 27); lower slots are 0.
  - Slot 28: V. Slot 29: U=0. Slot 30: C = cs_bits[frame] if frame<40, else 0.
  - Slot 31: P, chosen so slots 4..31 contain an even number of ones.
- Preambles (8 UIs, written for a preceding line level of 0):
  - B = 11101000 on subframe A of frame 0.
  - M = 11100010 on subframe A of other frames.
  - W = 11100100 on subframe B.
  - If the line is 1 before the preamble, the pattern is inverted.
- Data slots: the line toggles at the start of every slot and toggles again at mid-slot if the bit is 1.
- Invariant: the line level is identical at every subframe boundary (low from reset).
- en dropping in TX: at the next edge spdif_o=0, counters clear, state IDLE. The holding register contents are retained. A restart begins again at frame 0 with preamble B.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Test Plan:
- Reset, CLK_DIV=2, en=1, no samples: block_start/frame_start at the first TX cycle, underrun every frame. UIs 0-7 of subframe A read 1,1,1,0,1,0,0,0 (2 cycles each). Audio UIs show only start-of-slot toggles; V=1.
- Pair left=24'h000001, right=0, cs_bits=0, pushed before en: slot 4 UIs read 1,0. Subframe A P=1. Subframe B P=0 and its preamble is 11100100. s_ready returns to 1 at the frame load.
- SAMPLE_W=16, left=16'h8001: slots 4-11 are 0, slots 12 and 27 are 1, all others 0. P=0.
- cs_bits=40'h1 with continuous samples: C=1 only in frame 0, 0 in frames 1-191. block_start recurs after exactly 192x128xCLK_DIV cycles. Frame 1 uses preamble M.
- s_valid held high while s_ready=0: no second transfer. A pair offered at the load edge with the register empty gives underrun for that frame; that pair is transmitted in the next frame.
- en low mid-subframe: spdif_o=0 the next cycle. Re-enable restarts with preamble B and block_start, using the retained held pair, so no underrun occurs.
